// File: rtl/rom_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_boot_loader
// Summary  : Copies a length-prefixed ROM image into RAM and releases the CPU
//            from reset once the whole payload has been written.
// Revision : 1.0  initial release
// ============================================================================
module rom_boot_loader #(
  parameter logic [15:0] RAM_BASE  = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd4096
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [15:0] ram_address,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic        cpu_reset_n,
  output logic        boot_done,
  output logic        boot_error,
  output logic [31:0] checksum,
  output logic [15:0] words_copied
);

  localparam logic [2:0] c_st_header = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_write  = 3'd2;
  localparam logic [2:0] c_st_done   = 3'd3;
  localparam logic [2:0] c_st_error  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_length;
  logic [15:0] r_rom_address;
  logic [15:0] r_ram_address;
  logic [31:0] r_ram_wdata;
  logic        r_ram_we;
  logic        r_cpu_reset_n;
  logic        r_boot_done;
  logic        r_boot_error;
  logic [31:0] r_checksum;
  logic [15:0] r_words_copied;

  logic [15:0] w_next_count;
  logic [15:0] w_hdr_length;

  assign w_next_count = r_words_copied + 16'd1;
  assign w_hdr_length = rom_data[15:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= c_st_header;
      r_length       <= 16'd0;
      r_rom_address  <= 16'd0;
      r_ram_address  <= RAM_BASE;
      r_ram_wdata    <= 32'd0;
      r_ram_we       <= 1'b0;
      r_cpu_reset_n  <= 1'b0;
      r_boot_done    <= 1'b0;
      r_boot_error   <= 1'b0;
      r_checksum     <= 32'd0;
      r_words_copied <= 16'd0;
    end else begin
      // Status flags lag the terminal state by one cycle so they stay registered.
      r_boot_done   <= (r_state == c_st_done);
      r_cpu_reset_n <= (r_state == c_st_done);
      r_boot_error  <= (r_state == c_st_error);

      case (r_state)
        c_st_header: begin
          r_length <= w_hdr_length;
          if (w_hdr_length == 16'd0) begin
            r_state <= c_st_done;
          end else if (w_hdr_length > MAX_WORDS) begin
            r_state <= c_st_error;
          end else begin
            r_rom_address <= 16'd1;
            r_state       <= c_st_fetch;
          end
        end

        c_st_fetch: begin
          r_ram_wdata   <= rom_data;
          r_ram_address <= RAM_BASE + r_words_copied;
          r_ram_we      <= 1'b1;
          r_state       <= c_st_write;
        end

        c_st_write: begin
          if (ram_ready) begin
            r_checksum     <= r_checksum + r_ram_wdata;
            r_words_copied <= w_next_count;
            r_ram_we       <= 1'b0;
            if (w_next_count == r_length) begin
              r_state <= c_st_done;
            end else begin
              r_rom_address <= r_rom_address + 16'd1;
              r_state       <= c_st_fetch;
            end
          end
        end

        c_st_done, c_st_error: begin
        end

        default: begin
          // Unreachable encodings fail safe: keep the CPU parked and stop writing.
          r_ram_we <= 1'b0;
          r_state  <= c_st_error;
        end
      endcase
    end
  end

  assign rom_address  = r_rom_address;
  assign ram_address  = r_ram_address;
  assign ram_wdata    = r_ram_wdata;
  assign ram_we       = r_ram_we;
  assign cpu_reset_n  = r_cpu_reset_n;
  assign boot_done    = r_boot_done;
  assign boot_error   = r_boot_error;
  assign checksum     = r_checksum;
  assign words_copied = r_words_copied;

endmodule
`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_boot_loader
// Summary  : Self-checking bench for rom_boot_loader (default and wrapped RAM base).
// Revision : 1.0  initial release
// ============================================================================
module tb_rom_boot_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    int          stall_pct;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic        reset_n0 = 1'b0;
  logic [15:0] rom_address0;
  logic [31:0] rom_data0;
  logic [15:0] ram_address0;
  logic [31:0] ram_wdata0;
  logic        ram_we0;
  logic        ram_ready0 = 1'b1;
  logic        cpu_reset_n0, boot_done0, boot_error0;
  logic [31:0] checksum0;
  logic [15:0] words_copied0;

  // Instance 1: RAM base near the top of the address space
  logic        reset_n1 = 1'b0;
  logic [15:0] rom_address1;
  logic [31:0] rom_data1;
  logic [15:0] ram_address1;
  logic [31:0] ram_wdata1;
  logic        ram_we1;
  logic        ram_ready1 = 1'b1;
  logic        cpu_reset_n1, boot_done1, boot_error1;
  logic [31:0] checksum1;
  logic [15:0] words_copied1;

  logic [31:0] rom0 [0:65535];
  logic [31:0] rom1 [0:15];

  assign rom_data0 = rom0[rom_address0];
  assign rom_data1 = (rom_address1 < 16'd16) ? rom1[rom_address1[3:0]] : 32'd0;

  rom_boot_loader u_dut0 (
    .clk(clk), .reset_n(reset_n0),
    .rom_address(rom_address0), .rom_data(rom_data0),
    .ram_address(ram_address0), .ram_wdata(ram_wdata0),
    .ram_we(ram_we0), .ram_ready(ram_ready0),
    .cpu_reset_n(cpu_reset_n0), .boot_done(boot_done0), .boot_error(boot_error0),
    .checksum(checksum0), .words_copied(words_copied0)
  );

  rom_boot_loader #(.RAM_BASE(16'hFFFE), .MAX_WORDS(16'd4096)) u_dut1 (
    .clk(clk), .reset_n(reset_n1),
    .rom_address(rom_address1), .rom_data(rom_data1),
    .ram_address(ram_address1), .ram_wdata(ram_wdata1),
    .ram_we(ram_we1), .ram_ready(ram_ready1),
    .cpu_reset_n(cpu_reset_n1), .boot_done(boot_done1), .boot_error(boot_error1),
    .checksum(checksum1), .words_copied(words_copied1)
  );

  int passed = 0;
  int total  = 0;

  // RAM-side observers: accepted writes, stall stability, flag exclusivity
  wr_t         wq0[$];
  wr_t         wq1[$];
  int          stall_viol = 0;
  int          excl_viol  = 0;
  logic [15:0] maxrom0    = 16'd0;
  logic        p_we0 = 1'b0, p_rdy0 = 1'b0, p_rst0 = 1'b0;
  logic [15:0] p_addr0 = 16'd0;
  logic [31:0] p_data0 = 32'd0;

  always @(posedge clk) begin
    if (ram_we0 && ram_ready0) wq0.push_back({ram_address0, ram_wdata0});
    if (ram_we1 && ram_ready1) wq1.push_back({ram_address1, ram_wdata1});
    if (p_we0 && !p_rdy0 && p_rst0 &&
        (ram_we0 !== 1'b1 || ram_address0 !== p_addr0 || ram_wdata0 !== p_data0))
      stall_viol++;
    if ((boot_done0 && boot_error0) || (boot_done1 && boot_error1)) excl_viol++;
    if (reset_n0 && rom_address0 > maxrom0) maxrom0 = rom_address0;
    p_we0   = ram_we0;
    p_rdy0  = ram_ready0;
    p_rst0  = reset_n0;
    p_addr0 = ram_address0;
    p_data0 = ram_wdata0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves reset released at a negedge; the next posedge is posedge 1.
  task automatic reset_dut0();
    @(negedge clk);
    reset_n0 = 1'b0;
    step(2);
    reset_n0 = 1'b1;
    wq0.delete();
    maxrom0 = 16'd0;
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_rom_address"}, rom_address0, 16'd0);
    chk({tag, "_ram_we"}, ram_we0, 1'b0);
    chk({tag, "_ram_address"}, ram_address0, 16'h0000);
    chk({tag, "_ram_wdata"}, ram_wdata0, 32'd0);
    chk({tag, "_cpu_reset_n"}, cpu_reset_n0, 1'b0);
    chk({tag, "_flags"}, {boot_done0, boot_error0}, 2'b00);
    chk({tag, "_checksum"}, checksum0, 32'd0);
    chk({tag, "_words"}, words_copied0, 16'd0);
  endtask

  // Random payload, random RAM back-pressure; expectations from a plain copy model.
  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    int          budget;
    int          bad;
    logic [31:0] exp_sum;
    rom0[0] = {16'($urandom), v.len};
    for (int i = 1; i <= int'(v.len) && i < 65536; i++) rom0[i] = $urandom;
    ready_high0();
    reset_dut0();
    cyc    = 0;
    budget = 20 * int'(v.len) + 200;
    while (!(boot_done0 || boot_error0) && cyc < budget) begin
      ram_ready0 = ($urandom_range(99) >= v.stall_pct);
      @(negedge clk);
      cyc++;
    end
    ram_ready0 = 1'b1;
    step(20);
    exp_sum = 32'd0;
    bad     = 0;
    if (v.exp_done) begin
      for (int i = 1; i <= int'(v.len); i++) exp_sum += rom0[i];
      for (int i = 0; i < int'(v.len) && i < wq0.size(); i++)
        if (wq0[i].a !== 16'(i) || wq0[i].d !== rom0[i+1]) bad++;
    end
    chk($sformatf("v%0d_finished", idx), {31'd0, boot_done0 | boot_error0}, 32'd1);
    chk($sformatf("v%0d_done", idx), boot_done0, v.exp_done);
    chk($sformatf("v%0d_error", idx), boot_error0, v.exp_err);
    chk($sformatf("v%0d_cpu_reset_n", idx), cpu_reset_n0, v.exp_done);
    chk($sformatf("v%0d_words", idx), words_copied0, v.exp_done ? v.len : 16'd0);
    chk($sformatf("v%0d_checksum", idx), checksum0, exp_sum);
    chk($sformatf("v%0d_nwrites", idx), wq0.size(), v.exp_done ? 32'(v.len) : 32'd0);
    chk($sformatf("v%0d_write_content", idx), bad, 0);
    chk($sformatf("v%0d_rom_bound", idx), maxrom0, v.exp_done ? v.len : 16'd0);
    if (v.stall_pct == 0)
      chk($sformatf("v%0d_latency", idx), cyc, v.exp_err ? 2 : 2 + 2 * int'(v.len));
  endtask

  task automatic ready_high0();
    ram_ready0 = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    int bad;
    logic early;

    vecs[0] = '{16'd1,     0,  1'b1, 1'b0};
    vecs[1] = '{16'd2,     50, 1'b1, 1'b0};
    vecs[2] = '{16'd7,     30, 1'b1, 1'b0};
    vecs[3] = '{16'd16,    70, 1'b1, 1'b0};
    vecs[4] = '{16'd4096,  0,  1'b1, 1'b0};
    vecs[5] = '{16'd4097,  0,  1'b0, 1'b1};
    vecs[6] = '{16'hFFFF,  20, 1'b0, 1'b1};
    vecs[7] = '{16'($urandom_range(40, 2)), 40, 1'b1, 1'b0};
    vecs[8] = '{16'd0,     0,  1'b1, 1'b0};

    for (int i = 0; i < 65536; i++) rom0[i] = 32'd0;
    for (int i = 0; i < 16; i++) rom1[i] = 32'd0;

    // Reset state while reset is held
    step(3);
    check_reset0("rst");

    // Four-word copy with RAM always ready
    rom0[0] = 32'd4;
    rom0[1] = 32'h1111_1111; rom0[2] = 32'h2222_2222;
    rom0[3] = 32'h3333_3333; rom0[4] = 32'h4444_4444;
    ready_high0();
    reset_dut0();
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      early |= boot_done0 | cpu_reset_n0;
    end
    chk("t1_not_early", early, 1'b0);
    step(1);
    chk("t1_done", boot_done0, 1'b1);
    chk("t1_cpu_release", cpu_reset_n0, 1'b1);
    chk("t1_checksum", checksum0, 32'hAAAA_AAAA);
    chk("t1_words", words_copied0, 16'd4);
    bad = 0;
    for (int i = 0; i < 4 && i < wq0.size(); i++)
      if (wq0[i].a !== 16'(i) || wq0[i].d !== rom0[i+1]) bad++;
    chk("t1_nwrites", wq0.size(), 4);
    chk("t1_write_content", bad, 0);

    // Zero-length header; upper half of word 0 must be ignored
    rom0[0] = 32'hABCD_0000;
    reset_dut0();
    step(1);
    chk("t2_done_not_yet", boot_done0, 1'b0);
    step(1);
    chk("t2_done", boot_done0, 1'b1);
    chk("t2_cpu_release", cpu_reset_n0, 1'b1);
    chk("t2_checksum", checksum0, 32'd0);
    chk("t2_nwrites", wq0.size(), 0);

    // Oversized header: error held, no writes
    rom0[0] = 32'd4097;
    reset_dut0();
    step(2);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (boot_error0 !== 1'b1 || cpu_reset_n0 !== 1'b0 || boot_done0 !== 1'b0 || ram_we0 !== 1'b0)
        bad++;
      step(1);
    end
    chk("t3_error_held", bad, 0);
    chk("t3_nwrites", wq0.size(), 0);
    chk("t3_words", words_copied0, 16'd0);

    // Five-cycle stall on word 2 of 3
    rom0[0] = 32'd3;
    rom0[1] = 32'h0000_00A1; rom0[2] = 32'h0000_00B2; rom0[3] = 32'h0000_00C3;
    reset_dut0();
    step(4);
    chk("t4_we_word2", {ram_we0, ram_address0}, {1'b1, 16'd1});
    ram_ready0 = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (ram_we0 !== 1'b1 || ram_address0 !== 16'd1 || ram_wdata0 !== 32'h0000_00B2) bad++;
    end
    chk("t4_stall_stable", bad, 0);
    ram_ready0 = 1'b1;
    step(1);
    chk("t4_words_after_stall", words_copied0, 16'd2);
    step(2);
    chk("t4_words_at_12", words_copied0, 16'd3);
    chk("t4_done_not_yet", boot_done0, 1'b0);
    step(1);
    chk("t4_done_13", boot_done0, 1'b1);
    chk("t4_checksum", checksum0, 32'h0000_0216);

    // Reset pulse in the middle of word 2's write, then a full restart
    rom0[0] = 32'd4;
    rom0[1] = 32'h0101_0101; rom0[2] = 32'h0202_0202;
    rom0[3] = 32'h0303_0303; rom0[4] = 32'h0404_0404;
    reset_dut0();
    step(4);
    ram_ready0 = 1'b0;
    step(1);
    reset_n0 = 1'b0;
    step(1);
    check_reset0("t5_rst");
    reset_n0   = 1'b1;
    ram_ready0 = 1'b1;
    wq0.delete();
    step(10);
    chk("t5_done", boot_done0, 1'b1);
    chk("t5_words", words_copied0, 16'd4);
    chk("t5_checksum", checksum0, 32'h0A0A_0A0A);
    chk("t5_nwrites", wq0.size(), 4);

    // RAM base FFFE: address wrap and checksum wrap
    rom1[0] = 32'd4;
    for (int i = 1; i <= 4; i++) rom1[i] = 32'hFFFF_FFFF;
    reset_n1 = 1'b1;
    wq1.delete();
    step(10);
    chk("t6_done", boot_done1, 1'b1);
    chk("t6_checksum", checksum1, 32'hFFFF_FFFC);
    chk("t6_words", words_copied1, 16'd4);
    chk("t6_nwrites", wq1.size(), 4);
    bad = 0;
    for (int i = 0; i < 4 && i < wq1.size(); i++)
      if (wq1[i].a !== 16'hFFFE + 16'(i) || wq1[i].d !== 32'hFFFF_FFFF) bad++;
    chk("t6_addr_wrap", bad, 0);

    // Table of randomized copies
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    chk("stall_stability", stall_viol, 0);
    chk("done_error_exclusive", excl_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
